// File: rtl/pc_stack.sv
// pc_stack: program counter with hold/inc/jmp/bra/call/ret over a return stack; clk, clr (async low), en_pc, op, adrs_in -> adrs_out, sp, stk_full, stk_empty, stk_err
module pc_stack #(
  parameter int ADDR_W = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                               clk,
  input  logic                               clr,
  input  logic                               en_pc,
  input  logic [2:0]                         op,
  input  logic [ADDR_W-1:0]                  adrs_in,
  output logic [ADDR_W-1:0]                  adrs_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               stk_full,
  output logic                               stk_empty,
  output logic                               stk_err
);
  localparam int SPW = $clog2(STACK_DEPTH+1);
  localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  typedef enum logic [2:0] {OP_HOLD, OP_INC, OP_JMP, OP_BRA, OP_CALL, OP_RET} op_t;
  logic [ADDR_W-1:0] mem [2**IW];
  logic [ADDR_W-1:0] pc_inc, pc_nxt, top;
  logic [SPW-1:0] sp_m1, sp_nxt;
  logic is_call, is_ret, push, pop, err_nxt;
  assign stk_full = sp == SPW'(STACK_DEPTH);
  assign stk_empty = sp == '0;
  assign pc_inc = adrs_out + ADDR_W'(1);
  assign sp_m1 = sp - SPW'(1);
  assign top = mem[sp_m1[IW-1:0]];
  always_comb begin
    is_call = en_pc && op == OP_CALL;
    is_ret = en_pc && op == OP_RET;
    push = is_call && !stk_full;
    pop = is_ret && !stk_empty;
    err_nxt = (is_call && stk_full) || (is_ret && stk_empty);
    sp_nxt = push ? sp + SPW'(1) : pop ? sp_m1 : sp;
    pc_nxt = !en_pc ? adrs_out :
             op == OP_INC ? pc_inc :
             op == OP_JMP ? adrs_in :
             op == OP_BRA ? adrs_out + adrs_in :
             push ? adrs_in :
             pop ? top : adrs_out;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      adrs_out <= RESET_ADDR;
      sp <= '0;
      stk_err <= 1'b0;
    end else begin
      adrs_out <= pc_nxt;
      sp <= sp_nxt;
      stk_err <= err_nxt;
    end
  end
  always_ff @(posedge clk) if (push && clr) mem[sp[IW-1:0]] <= pc_inc;
endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the next processor generation.
- Replaces the plain loadable PC with selectable next-address operations: hold, increment, absolute jump, signed relative branch, and call/return through an internal hardware return-address stack.
- Sits between the control unit, which drives op/en_pc, and the instruction memory address bus, which is driven by adrs_out.

Parameters:
- ADDR_W, 8: address width in bits.
- STACK_DEPTH, 4: return-stack entries, must be >= 1.
- RESET_ADDR, 0: value loaded into the PC on reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous active-low reset; clr=0 resets immediately, independent of clk.
- en_pc  in  1  update enable; 0 freezes PC, stack and flags.
- op  in  3  next-address operation, sampled at posedge when en_pc=1.
- adrs_in  in  ADDR_W  jump target (JMP/CALL) or two's-complement offset (BRA).
- adrs_out  out  ADDR_W  current PC, registered.
- sp  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stk_full  out  1  sp == STACK_DEPTH.
- stk_empty  out  1  sp == 0.
- stk_err  out  1  one-cycle pulse on refused CALL or RET.

Behaviour:
- Reset (clr=0, asynchronous):
  - adrs_out=RESET_ADDR, sp=0, stk_empty=1, stk_full=0, stk_err=0.
  - Stack RAM contents are don't-care.
  - Reset asserted mid-operation aborts any push/pop in progress; no partial update survives.
- All outputs are registered; stk_full and stk_empty are decoded from the registered sp.
- Latency: op/adrs_in sampled at edge N are reflected on adrs_out after edge N.
- en_pc=0: adrs_out, sp and stack are held; stk_err=0; op is ignored.
- en_pc=1, op encoding:
  - 000 HOLD: PC unchanged.
  - 001 INC: PC <= PC+1, modulo 2^ADDR_W (all-ones wraps to 0).
  - 010 JMP: PC <= adrs_in.
  - 011 BRA: PC <= PC + sign-extended adrs_in, modulo 2^ADDR_W. Offset is relative to the current PC, not PC+1.
  - 100 CALL: stack[sp] <= PC+1 (wrapped), sp <= sp+1, PC <= adrs_in.
  - 101 RET: PC <= stack[sp-1], sp <= sp-1.
  - 110, 111 reserved: behave as HOLD; stk_err stays 0.
- CALL with stk_full=1:
  - No push, no jump, PC held, sp unchanged.
  - stk_err=1 for exactly that cycle.
- RET with stk_empty=1:
  - PC held, sp unchanged.
  - stk_err=1 for that cycle.
- stk_err returns to 0 on the next edge unless another refused CALL/RET occurs; back-to-back refusals keep it high.
- STACK_DEPTH=1: a single CALL sets full and empty=0 in the same cycle; a single RET restores empty.
- Stack is LIFO with no internal wrap; overflow and underflow are always refused, never overwritten.
- Deasserting clr is treated as synchronous to clk by the environment; the first operation executes on the first edge after release.

Test Plan:
- Reset and increment:
  - Stimulus: clr=0 for 2 cycles, release; en_pc=1, op=INC for 4 cycles (ADDR_W=8, RESET_ADDR=0).
  - Required: adrs_out=0 during reset, then 1,2,3,4; stk_empty=1, sp=0.
- Jump, branch and wrap:
  - Stimulus: JMP 0xFE, INC, INC, then BRA with adrs_in=0xFC.
  - Required: adrs_out=0xFE, 0xFF, 0x00, 0xFC.
  - Stimulus: from 0x10, BRA 0x05.
  - Required: 0x15.
- Enable gating:
  - Stimulus: at adrs_out=0x20, en_pc=0 with op=JMP 0x80 for 3 cycles, then en_pc=1, op=INC.
  - Required: adrs_out stays 0x20 for 3 cycles, then 0x21; sp and stk_err unchanged.
- Nested call/return (STACK_DEPTH=4):
  - Stimulus: at PC 0x05, CALL 0x40; at 0x40, CALL 0x60; RET; RET.
  - Required: adrs_out 0x40, 0x60, 0x41, 0x06; sp 1, 2, 1, 0.
- Overflow and underflow:
  - Stimulus: 4 CALLs, then a 5th CALL 0x99.
  - Required: after the 4th, stk_full=1; on the 5th, PC unchanged, sp=4, stk_err high for one cycle.
  - Stimulus: drain with 4 RETs, then one more RET.
  - Required: last RET gives PC unchanged, sp=0, stk_err pulse.
- Async reset mid-stack:
  - Stimulus: with sp=2, drive clr=0 between clock edges.
  - Required: adrs_out=RESET_ADDR, sp=0, stk_empty=1 before the next posedge.
  - Stimulus: after release, RET.
  - Required: stk_err pulse.
